ctech_lib_sync_filter: RTL

Synchronizes one asynchronous input onto `clk`, rejects glitches with a consecutive-sample qualifier, and drives the filtered level plus one-cycle edge pulses. It is the stage immediately upstream of the ctech buffer and driver cells. Its registered outputs feed them directly, so every downstream consumer sees a clean, glitch-free, clock-aligned level. It is used for straps, external request pins and cross-domain status bits.

---
 rtl/ctech_lib_sync_filter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ctech_lib_sync_filter.sv
// ctech_lib_sync_filter
// Synchronizes an asynchronous level onto clk, qualifies it with a
// consecutive-sample glitch filter and drives the filtered level plus
// one-cycle rise/fall pulses. All outputs come straight from flops.

module ctech_lib_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic en,
  output logic o,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("ctech_lib_sync_filter: SYNC_STAGES must be in 2..4");
  end
  if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_filt_cycles
    $error("ctech_lib_sync_filter: FILT_CYCLES must be in 1..255");
  end

  typedef enum logic {
    IDLE,
    QUAL
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          o_q;
  logic          rise_q;
  logic          fall_q;
  logic          busy_q;

  // Next value of the synchronizer chain: shift the raw input in at stage 0.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], a};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain; runs independently of the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Qualifier FSM with registered level, edge pulses and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_q     <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (!en) begin
        // Enable is evaluated ahead of any qualification outcome, so a
        // drop on the completing cycle suppresses the update.
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (s != o_q) begin
              if (FILT_CYCLES == 1) begin
                o_q    <= s;
                rise_q <= s;
                fall_q <= ~s;
                busy_q <= 1'b0;
              end else begin
                state_q <= QUAL;
                cnt_q   <= CNT_ONE;
                busy_q  <= 1'b1;
              end
            end else begin
              busy_q <= 1'b0;
            end
          end
          QUAL: begin
            if (s == o_q) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else if (cnt_q == CNT_LAST) begin
              o_q     <= s;
              rise_q  <= s;
              fall_q  <= ~s;
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q  <= cnt_q + CNT_ONE;
              busy_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o    = o_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule
